prio_req_encoder: RTL

Sequential priority encoder, the encoding counterpart of the 3-bit code classifiers in the lab testbenches. It latches up to eight request lines into a sticky pending register and selects the highest-priority unmasked request (index 0 highest). It offers that index as a 3-bit code over a valid/ready handshake and retires the request on acceptance. It sits between request sources and any consumer that dispatches on a binary code via `priority casez` / `unique case`.

---
 rtl/prio_enc_pkg.sv | 23 ++
 rtl/prio_first_one.sv | 29 ++
 rtl/prio_req_encoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_pkg
// Brief    : Shared state type, widths and helpers for prio_req_encoder.
// Revision : 1.0  initial release
// ============================================================================
package prio_enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } prio_state_t;

  localparam int DROP_CNT_W = 8;
  localparam int MAX_REQ    = 16;

  // Clearing the lowest set bit leaves something behind iff two or more bits were set.
  function automatic logic popcount_gt1(input logic [MAX_REQ-1:0] v);
    return |(v & (v - MAX_REQ'(1)));
  endfunction

endpackage : prio_enc_pkg
`default_nettype wire

// File: rtl/prio_first_one.sv
`default_nettype none
// ============================================================================
// Module   : prio_first_one
// Brief    : Combinational first-set finder, index 0 highest priority.
// Revision : 1.0  initial release
// ============================================================================
module prio_first_one #(
  parameter int N_REQ = 8,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scanning from the top down lets the lowest set index overwrite last.
  always_comb begin
    o_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

  assign o_any = |i_vec;

endmodule : prio_first_one
`default_nettype wire

// File: rtl/prio_req_encoder.sv
`default_nettype none
// ============================================================================
// Module   : prio_req_encoder
// Brief    : Sticky request latch with first-one selection, offering the
//            winning index as a binary code over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module prio_req_encoder
  import prio_enc_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ-1:0]      mask_i,
  output logic [IDX_W-1:0]      code_o,
  output logic                  code_valid_o,
  input  logic                  code_ready_i,
  output logic                  multi_o,
  output logic [N_REQ-1:0]      pend_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam logic [N_REQ-1:0] C_ONE = N_REQ'(1);

  prio_state_t           r_state;
  logic [N_REQ-1:0]      r_pend;
  logic [IDX_W-1:0]      r_code;
  logic                  r_valid;
  logic                  r_multi;
  logic [DROP_CNT_W-1:0] r_drop;

  logic [N_REQ-1:0]      w_elig;
  logic [N_REQ-1:0]      w_clr;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_hs;
  logic                  w_collide;

  assign w_elig    = r_pend & ~mask_i;
  assign w_hs      = r_valid & code_ready_i;
  assign w_clr     = w_hs ? (C_ONE << r_code) : '0;
  // A bit being retired this cycle cannot collide; a re-request simply re-arms it.
  assign w_collide = |(req_i & r_pend & ~w_clr);

  prio_first_one #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_first_one (
    .i_vec (w_elig),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | req_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_collide && (r_drop != '1)) begin
      r_drop <= r_drop + DROP_CNT_W'(1);
    end
  end

  // Code and multi flag are only loaded on the IDLE->OFFER transition, so they
  // stay frozen for the whole offer regardless of later mask or pending changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_code  <= '0;
      r_multi <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= OFFER;
            r_valid <= 1'b1;
            r_code  <= w_idx;
            r_multi <= popcount_gt1(MAX_REQ'(w_elig));
          end
        end
        OFFER: begin
          if (code_ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign code_o       = r_code;
  assign code_valid_o = r_valid;
  assign multi_o      = r_multi;
  assign pend_o       = r_pend;
  assign drop_cnt_o   = r_drop;

endmodule : prio_req_encoder
`default_nettype wire
